// File: rtl/imem_loader.sv
// Host-side instruction-memory loader: streams a program into consecutive
// addresses from 0, then enables the CPU until it halts.
module imem_loader #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [BUS_WIDTH-1:0]  in_data,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [BUS_WIDTH-1:0]  im_wdata,
    input  logic                  cpu_halt,
    output logic                  cpu_run,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_e;

    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ONE_W   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_P   = ADDR_WIDTH'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   words_loaded_q, words_loaded_d;
    logic                  im_we_q, im_we_d;
    logic [ADDR_WIDTH-1:0] im_addr_q, im_addr_d;
    logic [BUS_WIDTH-1:0]  im_wdata_q, im_wdata_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic start_ok;
    logic beat;
    logic last_beat;

    assign in_ready  = (state_q == LOAD) && !abort;
    assign cpu_run   = (state_q == RUN);
    assign beat      = in_valid && in_ready;
    assign start_ok  = (len != '0) && (len <= DEPTH_W);
    assign last_beat = beat && ((words_loaded_q + ONE_W) == len_q);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && start_ok) state_d = LOAD;
            LOAD:    if (abort) state_d = IDLE;
                     else if (last_beat) state_d = FLUSH;
            FLUSH:   state_d = RUN;
            RUN:     if (cpu_halt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        len_d          = len_q;
        ptr_d          = ptr_q;
        words_loaded_d = words_loaded_q;
        im_we_d        = 1'b0;
        im_addr_d      = im_addr_q;
        im_wdata_d     = im_wdata_q;
        done_d         = 1'b0;
        error_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && start_ok) begin
                    len_d          = len;
                    ptr_d          = '0;
                    words_loaded_d = '0;
                end else if (start) begin
                    error_d = 1'b1;
                end
            end
            LOAD: begin
                // in_ready already excludes abort, so an aborted cycle never writes.
                if (abort) begin
                    error_d = 1'b1;
                end else if (beat) begin
                    im_we_d        = 1'b1;
                    im_addr_d      = ptr_q;
                    im_wdata_d     = in_data;
                    ptr_d          = ptr_q + ONE_P;
                    words_loaded_d = words_loaded_q + ONE_W;
                end
            end
            RUN: begin
                if (cpu_halt) done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            len_q          <= '0;
            ptr_q          <= '0;
            words_loaded_q <= '0;
            im_we_q        <= 1'b0;
            im_addr_q      <= '0;
            im_wdata_q     <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            len_q          <= len_d;
            ptr_q          <= ptr_d;
            words_loaded_q <= words_loaded_d;
            im_we_q        <= im_we_d;
            im_addr_q      <= im_addr_d;
            im_wdata_q     <= im_wdata_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign im_we        = im_we_q;
    assign im_addr      = im_addr_q;
    assign im_wdata     = im_wdata_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized program loads compared against
// a word-k-goes-to-address-k model with one-cycle write latency.
module tb_imem_loader;

    localparam int BW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          CLK = 1'b0;
    logic          RST_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          cpu_halt = 1'b0;
    logic          in_ready, im_we, cpu_run, done, error;
    logic [AW-1:0] im_addr;
    logic [BW-1:0] im_wdata;
    logic [AW:0]   words_loaded;

    imem_loader #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_n(RST_n), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_halt(cpu_halt), .cpu_run(cpu_run), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 CLK = ~CLK;

    typedef struct { int addr; logic [BW-1:0] data; int cyc; } wr_t;

    wr_t           wr_q[$];
    int            hs_q[$];
    int            cyc = 0;
    int            run_rise = -1;
    int            run_cnt = 0, done_cnt = 0, err_cnt = 0, overlap = 0;
    logic          run_prev = 1'b0;
    logic [BW-1:0] data_arr [0:DEPTH-1];
    int            n_vec = 0, n_err = 0;

    always @(posedge CLK) cyc++;

    // Observation log, sampled mid-cycle; a handshake seen in cycle c transfers at the end of c.
    always @(negedge CLK) begin
        if (im_we) wr_q.push_back('{int'(im_addr), im_wdata, cyc});
        if (in_valid && in_ready) hs_q.push_back(cyc);
        if (cpu_run && !run_prev && run_rise < 0) run_rise = cyc;
        if (cpu_run) run_cnt++;
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (cpu_run && im_we) overlap++;
        run_prev = cpu_run;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        wr_q.delete();
        hs_q.delete();
        run_rise = -1;
        run_cnt  = 0;
        done_cnt = 0;
        err_cnt  = 0;
        overlap  = 0;
        run_prev = cpu_run;
    endtask

    task automatic pulse_start(input logic [AW:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
        len   = (AW + 1)'($urandom());
    endtask

    task automatic do_halt();
        cpu_halt = 1'b1;
        step();
        cpu_halt = 1'b0;
        step();
    endtask

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (cpu_run) ok = 1'b1;
            else step();
        end
    endtask

    // Offers data_arr[0..n-1]; mode 0 = always valid, 1 = alternating, 2 = random.
    task automatic drive_load(input int n, input int mode, input int abort_beat, output bit timed_out);
        int sent = 0;
        int guard = 0;
        bit ab;
        timed_out = 1'b0;
        while (sent < n) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = ((guard % 2) == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? data_arr[sent] : $urandom();
            ab      = in_valid && (sent == abort_beat);
            abort   = ab;
            #1;
            if (in_valid && in_ready) sent++;
            step();
            abort = 1'b0;
            guard++;
            if (ab) break;
            if (guard > 4000) begin
                timed_out = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_vec++;
        if ({im_we, in_ready, cpu_run, done, error} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b, want 00000", {im_we, in_ready, cpu_run, done, error});
        end
        n_vec++;
        if (im_addr !== '0 || im_wdata !== '0 || words_loaded !== '0) begin
            n_err++;
            $display("FAIL reset_regs: got addr=%0h wdata=%0h wl=%0d, want 0 0 0", im_addr, im_wdata, words_loaded);
        end
        @(negedge CLK);
        RST_n = 1'b1;
        step();
        n_vec++;
        if (in_ready !== 1'b0 || cpu_run !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got in_ready=%b cpu_run=%b, want 0 0", in_ready, cpu_run);
        end
    endtask

    task automatic test_back_to_back();
        bit to, ok;
        for (int k = 0; k < 4; k++) data_arr[k] = 32'h1000_0001 + k;
        clear_logs();
        pulse_start(9'd4);
        drive_load(4, 0, -1, to);
        n_vec++;
        if (to || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_flush: got timeout=%b in_ready=%b, want 0 0", to, in_ready);
        end
        wait_run(ok);
        step();
        n_vec++;
        if (wr_q.size() != 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d writes, want 4", wr_q.size());
        end
        for (int k = 0; k < wr_q.size() && k < 4 && k < hs_q.size(); k++) begin
            n_vec++;
            if (wr_q[k].addr != k || wr_q[k].data !== data_arr[k] || wr_q[k].cyc != hs_q[k] + 1
                || wr_q[k].cyc != wr_q[0].cyc + k) begin
                n_err++;
                $display("FAIL b2b_write%0d: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d",
                         k, wr_q[k].addr, wr_q[k].data, wr_q[k].cyc, k, data_arr[k], hs_q[k] + 1);
            end
        end
        n_vec++;
        if (!ok || wr_q.size() == 0 || run_rise != wr_q[$].cyc + 1 || overlap != 0) begin
            n_err++;
            $display("FAIL b2b_run_rise: got cycle %0d, want %0d", run_rise, (wr_q.size() > 0) ? wr_q[$].cyc + 1 : -1);
        end
        n_vec++;
        if (words_loaded !== 9'd4) begin
            n_err++;
            $display("FAIL b2b_words: got %0d, want 4", words_loaded);
        end
    endtask

    task automatic test_halt_reload();
        bit to, ok;
        repeat ($urandom_range(1, 4)) step();
        cpu_halt = 1'b1;
        #1;
        n_vec++;
        if (cpu_run !== 1'b1) begin
            n_err++;
            $display("FAIL halt_before: got cpu_run=%b, want 1", cpu_run);
        end
        step();
        cpu_halt = 1'b0;
        n_vec++;
        if (done !== 1'b1 || cpu_run !== 1'b0 || words_loaded !== 9'd4) begin
            n_err++;
            $display("FAIL halt_done: got done=%b cpu_run=%b wl=%0d, want 1 0 4", done, cpu_run, words_loaded);
        end
        step();
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL halt_done_pulse: got done=%b, want 0", done);
        end
        data_arr[0] = $urandom();
        clear_logs();
        pulse_start(9'd1);
        drive_load(1, 0, -1, to);
        wait_run(ok);
        step();
        n_vec++;
        if (to || !ok || wr_q.size() != 1 || wr_q[0].addr != 0 || wr_q[0].data !== data_arr[0]
            || run_rise != wr_q[0].cyc + 1) begin
            n_err++;
            $display("FAIL reload: got writes=%0d addr=%0d data=%h run=%b, want 1 0 %h 1",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0].addr : -1,
                     (wr_q.size() > 0) ? wr_q[0].data : 32'h0, ok, data_arr[0]);
        end
        do_halt();
    endtask

    task automatic test_gaps();
        bit to, ok;
        for (int k = 0; k < 3; k++) data_arr[k] = $urandom();
        clear_logs();
        pulse_start(9'd3);
        drive_load(3, 1, -1, to);
        wait_run(ok);
        step();
        n_vec++;
        if (to || !ok || wr_q.size() != 3 || hs_q.size() != 3) begin
            n_err++;
            $display("FAIL gaps_count: got writes=%0d beats=%0d run=%b, want 3 3 1", wr_q.size(), hs_q.size(), ok);
        end
        for (int k = 0; k < wr_q.size() && k < 3 && k < hs_q.size(); k++) begin
            n_vec++;
            if (wr_q[k].addr != k || wr_q[k].data !== data_arr[k] || wr_q[k].cyc != hs_q[k] + 1
                || hs_q[k] != hs_q[0] + 2 * k) begin
                n_err++;
                $display("FAIL gaps_write%0d: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d",
                         k, wr_q[k].addr, wr_q[k].data, wr_q[k].cyc, k, data_arr[k], hs_q[0] + 2 * k + 1);
            end
        end
        do_halt();
    endtask

    task automatic test_bad_len();
        logic [AW:0] bad [3] = '{9'd0, 9'd257, 9'd511};
        for (int i = 0; i < 3; i++) begin
            clear_logs();
            in_valid = 1'b1;
            start    = 1'b1;
            len      = bad[i];
            step();
            start = 1'b0;
            n_vec++;
            if (error !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bad_len%0d_err: got error=%b in_ready=%b, want 1 0", bad[i], error, in_ready);
            end
            step();
            step();
            in_valid = 1'b0;
            n_vec++;
            if (error !== 1'b0 || in_ready !== 1'b0 || wr_q.size() != 0 || err_cnt != 1) begin
                n_err++;
                $display("FAIL bad_len%0d_idle: got error=%b in_ready=%b writes=%0d err_cycles=%0d, want 0 0 0 1",
                         bad[i], error, in_ready, wr_q.size(), err_cnt);
            end
        end
    endtask

    task automatic test_depth();
        bit to, ok;
        int bad_cnt = 0;
        for (int k = 0; k < DEPTH; k++) data_arr[k] = $urandom();
        clear_logs();
        pulse_start(9'(DEPTH));
        drive_load(DEPTH, 2, -1, to);
        wait_run(ok);
        step();
        for (int k = 0; k < wr_q.size() && k < DEPTH && k < hs_q.size(); k++)
            if (wr_q[k].addr != k || wr_q[k].data !== data_arr[k] || wr_q[k].cyc != hs_q[k] + 1) bad_cnt++;
        n_vec++;
        if (to || wr_q.size() != DEPTH || bad_cnt != 0) begin
            n_err++;
            $display("FAIL depth_writes: got %0d writes with %0d wrong, want %0d with 0 wrong", wr_q.size(), bad_cnt, DEPTH);
        end
        n_vec++;
        if (!ok || wr_q.size() == 0 || wr_q[$].addr != DEPTH - 1 || run_rise != wr_q[$].cyc + 1) begin
            n_err++;
            $display("FAIL depth_last: got addr=%0d run_rise=%0d, want addr=%0d run one cycle after last write",
                     (wr_q.size() > 0) ? wr_q[$].addr : -1, run_rise, DEPTH - 1);
        end
        n_vec++;
        if (words_loaded !== 9'(DEPTH)) begin
            n_err++;
            $display("FAIL depth_words: got %0d, want %0d", words_loaded, DEPTH);
        end
        do_halt();
    endtask

    task automatic test_abort();
        bit to;
        for (int k = 0; k < 5; k++) data_arr[k] = $urandom();
        clear_logs();
        pulse_start(9'd5);
        drive_load(5, 0, 2, to);
        n_vec++;
        if (error !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL abort_err: got error=%b in_ready=%b, want 1 0", error, in_ready);
        end
        in_valid = 1'b1;
        repeat (5) step();
        in_valid = 1'b0;
        n_vec++;
        if (wr_q.size() != 2 || run_cnt != 0 || err_cnt != 1 || words_loaded !== 9'd2) begin
            n_err++;
            $display("FAIL abort_state: got writes=%0d run_cycles=%0d err_cycles=%0d wl=%0d, want 2 0 1 2",
                     wr_q.size(), run_cnt, err_cnt, words_loaded);
        end
        for (int k = 0; k < wr_q.size() && k < 2 && k < hs_q.size(); k++) begin
            n_vec++;
            if (wr_q[k].addr != k || wr_q[k].data !== data_arr[k] || wr_q[k].cyc != hs_q[k] + 1) begin
                n_err++;
                $display("FAIL abort_write%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                         k, wr_q[k].addr, wr_q[k].data, k, data_arr[k]);
            end
        end
    endtask

    task automatic test_ignored();
        bit to, ok;
        for (int k = 0; k < 3; k++) data_arr[k] = $urandom();
        clear_logs();
        pulse_start(9'd3);
        start = 1'b1;
        len   = 9'd0;
        drive_load(3, 0, -1, to);
        wait_run(ok);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        n_vec++;
        if (!ok || cpu_run !== 1'b1 || err_cnt != 0 || wr_q.size() != 3) begin
            n_err++;
            $display("FAIL ignored_run: got run=%b err_cycles=%0d writes=%0d, want 1 0 3", cpu_run, err_cnt, wr_q.size());
        end
        start = 1'b0;
        do_halt();
        cpu_halt = 1'b1;
        step();
        cpu_halt = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        n_vec++;
        if (done_cnt != 1 || err_cnt != 0 || in_ready !== 1'b0 || cpu_run !== 1'b0 || words_loaded !== 9'd3) begin
            n_err++;
            $display("FAIL ignored_idle: got done_cycles=%0d err_cycles=%0d in_ready=%b run=%b wl=%0d, want 1 0 0 0 3",
                     done_cnt, err_cnt, in_ready, cpu_run, words_loaded);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int l     = $urandom_range(1, 24);
            int ab    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, l - 1) : -1;
            int n_exp = (ab < 0) ? l : ab;
            bit to, ok;
            for (int k = 0; k < l; k++) data_arr[k] = $urandom();
            clear_logs();
            pulse_start(9'(l));
            drive_load(l, 2, ab, to);
            ok = 1'b0;
            if (ab < 0) wait_run(ok);
            repeat (2) step();
            n_vec++;
            if (to || wr_q.size() != n_exp) begin
                n_err++;
                $display("FAIL rand%0d_count: got %0d writes, want %0d", it, wr_q.size(), n_exp);
            end
            for (int k = 0; k < wr_q.size() && k < n_exp && k < hs_q.size(); k++) begin
                n_vec++;
                if (wr_q[k].addr != k || wr_q[k].data !== data_arr[k] || wr_q[k].cyc != hs_q[k] + 1) begin
                    n_err++;
                    $display("FAIL rand%0d_write%0d: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d",
                             it, k, wr_q[k].addr, wr_q[k].data, wr_q[k].cyc, k, data_arr[k], hs_q[k] + 1);
                end
            end
            n_vec++;
            if (words_loaded !== 9'(n_exp)) begin
                n_err++;
                $display("FAIL rand%0d_words: got %0d, want %0d", it, words_loaded, n_exp);
            end
            if (ab < 0) begin
                n_vec++;
                if (!ok || wr_q.size() == 0 || run_rise != wr_q[$].cyc + 1 || overlap != 0) begin
                    n_err++;
                    $display("FAIL rand%0d_run: got run_rise=%0d, want one cycle after last write", it, run_rise);
                end
                do_halt();
                n_vec++;
                if (done_cnt != 1 || err_cnt != 0) begin
                    n_err++;
                    $display("FAIL rand%0d_done: got done_cycles=%0d err_cycles=%0d, want 1 0", it, done_cnt, err_cnt);
                end
            end else begin
                n_vec++;
                if (run_cnt != 0 || err_cnt != 1) begin
                    n_err++;
                    $display("FAIL rand%0d_abort: got run_cycles=%0d err_cycles=%0d, want 0 1", it, run_cnt, err_cnt);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to, ok;
        for (int k = 0; k < 8; k++) data_arr[k] = $urandom() | 32'h1;
        clear_logs();
        pulse_start(9'd8);
        drive_load(3, 0, -1, to);
        in_valid = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || im_we !== 1'b1) begin
            n_err++;
            $display("FAIL rst_load_pre: got in_ready=%b im_we=%b, want 1 1", in_ready, im_we);
        end
        RST_n = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b0 || im_we !== 1'b0 || im_addr !== '0 || im_wdata !== '0 || words_loaded !== '0) begin
            n_err++;
            $display("FAIL rst_load: got in_ready=%b im_we=%b addr=%0h wdata=%h wl=%0d, want all 0",
                     in_ready, im_we, im_addr, im_wdata, words_loaded);
        end
        in_valid = 1'b0;
        step();
        @(negedge CLK);
        RST_n = 1'b1;
        clear_logs();
        pulse_start(9'd2);
        drive_load(2, 0, -1, to);
        wait_run(ok);
        n_vec++;
        if (!ok || cpu_run !== 1'b1) begin
            n_err++;
            $display("FAIL rst_run_pre: got cpu_run=%b, want 1", cpu_run);
        end
        #2;
        RST_n = 1'b0;
        #1;
        n_vec++;
        if (cpu_run !== 1'b0 || done !== 1'b0 || error !== 1'b0 || words_loaded !== '0) begin
            n_err++;
            $display("FAIL rst_run: got cpu_run=%b done=%b error=%b wl=%0d, want 0 0 0 0", cpu_run, done, error, words_loaded);
        end
        clear_logs();
        repeat (2) step();
        @(negedge CLK);
        RST_n = 1'b1;
        repeat (3) step();
        n_vec++;
        if (done_cnt != 0 || err_cnt != 0 || run_cnt != 0) begin
            n_err++;
            $display("FAIL rst_no_pulse: got done=%0d err=%0d run=%0d cycles, want 0 0 0", done_cnt, err_cnt, run_cnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit reached, want self-termination");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_halt_reload();
        test_gaps();
        test_bad_len();
        test_depth();
        test_abort();
        test_ignored();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
